// File: rtl/chunked_carry_adder.sv
// Multi-cycle add/subtract that processes CHUNK bits per clock and
// keeps the inter-chunk carry in a register, LSB chunk first.
module chunked_carry_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   add_w;
  logic [CHUNK-1:0] s_w;
  logic             cy_w;
  logic             msb_cin;
  logic             last;

  // Chunk slice, chunk adder and next-state / result update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    a_c     = '0;
    b_c     = '0;

    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_c = a_q[i*CHUNK +: CHUNK];
        b_c = b_q[i*CHUNK +: CHUNK];
      end
    end

    add_w = {1'b0, a_c} + {1'b0, b_c}
          + {{CHUNK{1'b0}}, carry_q};
    s_w   = add_w[CHUNK-1:0];
    cy_w  = add_w[CHUNK];
    // carry into the top bit of this chunk
    msb_cin = a_c[CHUNK-1] ^ b_c[CHUNK-1]
            ^ s_w[CHUNK-1];
    last  = (cnt_q == CW'(N - 1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ^ c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) begin
            part_d[i*CHUNK +: CHUNK] = s_w;
          end
        end
        carry_d = cy_w;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = part_d;
          cout_d  = cy_w;
          ovf_d   = msb_cin ^ cy_w;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_carry_adder.sv
// Directed bench for chunked_carry_adder: 16/4, 4/4 and 4/1 builds.
// Expected values are hand-computed constants.
module tb_chunked_carry_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 16-bit, 4-bit chunks
  logic        h_start = 0, h_sub = 0, h_cin = 0;
  logic [15:0] h_a = '0, h_b = '0, h_sum;
  logic        h_busy, h_done, h_cout, h_ovf;
  // 4-bit, single chunk
  logic        p_start = 0, p_sub = 0, p_cin = 0;
  logic [3:0]  p_a = '0, p_b = '0, p_sum;
  logic        p_busy, p_done, p_cout, p_ovf;
  // 4-bit, bit-serial
  logic        q_start = 0, q_sub = 0, q_cin = 0;
  logic [3:0]  q_a = '0, q_b = '0, q_sum;
  logic        q_busy, q_done, q_cout, q_ovf;

  chunked_carry_adder #(.WIDTH(16), .CHUNK(4)) u_h (
    .clk(clk), .rst_n(rst_n), .start(h_start), .sub(h_sub),
    .a(h_a), .b(h_b), .c_in(h_cin), .busy(h_busy), .done(h_done),
    .sum(h_sum), .c_out(h_cout), .overflow(h_ovf)
  );

  chunked_carry_adder #(.WIDTH(4), .CHUNK(4)) u_p (
    .clk(clk), .rst_n(rst_n), .start(p_start), .sub(p_sub),
    .a(p_a), .b(p_b), .c_in(p_cin), .busy(p_busy), .done(p_done),
    .sum(p_sum), .c_out(p_cout), .overflow(p_ovf)
  );

  chunked_carry_adder #(.WIDTH(4), .CHUNK(1)) u_q (
    .clk(clk), .rst_n(rst_n), .start(q_start), .sub(q_sub),
    .a(q_a), .b(q_b), .c_in(q_cin), .busy(q_busy), .done(q_done),
    .sum(q_sum), .c_out(q_cout), .overflow(q_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit op; operands are scrambled during RUN.
  task automatic run16(input string t, input logic sb,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic [15:0] es,
                       input logic ec, input logic eo);
    h_sub = sb; h_a = x; h_b = y; h_cin = ci; h_start = 1;
    tick();
    h_start = 0;
    h_a = ~x; h_b = x ^ y; h_cin = ~ci; h_sub = ~sb;
    for (int i = 0; i < 4; i++) begin
      chk({t, ".busy"}, 32'(h_busy), 32'd1);
      chk({t, ".early"}, 32'(h_done), 32'd0);
      tick();
    end
    chk({t, ".done"}, 32'(h_done), 32'd1);
    chk({t, ".idle"}, 32'(h_busy), 32'd0);
    chk({t, ".sum"}, 32'(h_sum), 32'(es));
    chk({t, ".cout"}, 32'(h_cout), 32'(ec));
    chk({t, ".ovf"}, 32'(h_ovf), 32'(eo));
    tick();
    chk({t, ".pulse"}, 32'(h_done), 32'd0);
    chk({t, ".hold"}, 32'(h_sum), 32'(es));
  endtask

  // One bit-serial 4-bit op.
  task automatic runq(input string t, input logic sb,
                      input logic [3:0] x, input logic [3:0] y,
                      input logic ci, input logic [3:0] es,
                      input logic ec, input logic eo);
    q_sub = sb; q_a = x; q_b = y; q_cin = ci; q_start = 1;
    tick();
    q_start = 0;
    for (int i = 0; i < 4; i++) begin
      chk({t, ".early"}, 32'(q_done), 32'd0);
      tick();
    end
    chk({t, ".done"}, 32'(q_done), 32'd1);
    chk({t, ".sum"}, 32'(q_sum), 32'(es));
    chk({t, ".cout"}, 32'(q_cout), 32'(ec));
    chk({t, ".ovf"}, 32'(q_ovf), 32'(eo));
  endtask

  int ndone;

  initial begin
    #2;
    chk("rst.busy", 32'(h_busy), 32'd0);
    chk("rst.done", 32'(h_done), 32'd0);
    chk("rst.sum", 32'(h_sum), 32'd0);
    chk("rst.cout", 32'(h_cout), 32'd0);
    chk("rst.ovf", 32'(h_ovf), 32'd0);
    tick();
    rst_n = 1;
    tick();

    run16("add1", 0, 16'h5A5A, 16'hA5A5, 1, 16'h0000, 1, 0);
    run16("add2", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    run16("sub1", 1, 16'h0003, 16'h0005, 0, 16'hFFFE, 0, 0);
    run16("sub2", 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1);

    // single-chunk build: done one cycle after start
    p_a = 4'b0101; p_b = 4'b1011; p_cin = 1; p_start = 1;
    tick();
    p_start = 0;
    chk("p.busy", 32'(p_busy), 32'd1);
    chk("p.early", 32'(p_done), 32'd0);
    tick();
    chk("p.done", 32'(p_done), 32'd1);
    chk("p.sum", 32'(p_sum), 32'h1);
    chk("p.cout", 32'(p_cout), 32'd1);
    chk("p.ovf", 32'(p_ovf), 32'd0);

    runq("q.add", 0, 4'b0111, 4'b1001, 0, 4'b0000, 1, 0);
    runq("q.sub", 1, 4'b1000, 4'b0001, 0, 4'b0111, 1, 1);

    // start held high: second op accepted in the done cycle
    h_sub = 0; h_a = 16'h1234; h_b = 16'h1111; h_cin = 0;
    h_start = 1;
    tick();
    h_sub = 1; h_a = 16'h0010; h_b = 16'h0020; h_cin = 0;
    repeat (3) tick();
    tick();
    chk("b2b.done1", 32'(h_done), 32'd1);
    chk("b2b.sum1", 32'(h_sum), 32'h2345);
    tick();
    chk("b2b.acc", 32'(h_busy), 32'd1);
    chk("b2b.gap", 32'(h_done), 32'd0);
    h_start = 0;
    repeat (3) tick();
    tick();
    chk("b2b.done2", 32'(h_done), 32'd1);
    chk("b2b.sum2", 32'(h_sum), 32'hFFF0);
    chk("b2b.cout2", 32'(h_cout), 32'd0);
    tick();

    // start while busy is ignored
    h_sub = 0; h_a = 16'h0100; h_b = 16'h0200; h_cin = 0;
    h_start = 1;
    tick();
    h_start = 0;
    tick();
    h_start = 1; h_a = 16'h0F00; h_b = 16'h0F00;
    tick();
    h_start = 0;
    tick();
    tick();
    chk("ign.done", 32'(h_done), 32'd1);
    chk("ign.sum", 32'(h_sum), 32'h0300);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ndone += int'(h_done);
    end
    chk("ign.extra", 32'(ndone), 32'd0);
    chk("ign.idle", 32'(h_busy), 32'd0);

    // reset two cycles into RUN
    h_sub = 0; h_a = 16'h7FFF; h_b = 16'h7FFF; h_cin = 1;
    h_start = 1;
    tick();
    h_start = 0;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("mid.busy", 32'(h_busy), 32'd0);
    chk("mid.done", 32'(h_done), 32'd0);
    chk("mid.sum", 32'(h_sum), 32'd0);
    chk("mid.cout", 32'(h_cout), 32'd0);
    chk("mid.ovf", 32'(h_ovf), 32'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ndone += int'(h_done);
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ndone += int'(h_done);
    end
    chk("mid.nodone", 32'(ndone), 32'd0);
    run16("post", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
